// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard/stall controller.
package hazard_pkg;

    // Controller state encoding
    localparam logic [0:0] RUN     = 1'b0;
    localparam logic [0:0] MD_WAIT = 1'b1;

    // Default EX-stage mul/div busy cycles after issue
    localparam int unsigned MD_LATENCY_DEFAULT = 32;

    // Hard-wired zero register; never a real producer
    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage : hazard_pkg

// File: rtl/hazard_stall_ctrl_md_busy_timer.sv
// Mul/div occupancy countdown: loaded on issue, counts down while active.
module md_busy_timer
    import hazard_pkg::*;
#(
    parameter int unsigned LATENCY = MD_LATENCY_DEFAULT,
    parameter int unsigned CNT_W   = 8
) (
    input  logic Clock,
    input  logic Reset,
    input  logic Load,
    input  logic Active,
    output logic Busy,
    output logic Done
);

    logic [CNT_W-1:0] md_cnt;

    // Countdown register; holds at zero once the operation has finished
    always_ff @(posedge Clock) begin
        if (Reset) begin
            md_cnt <= '0;
        end else if (Load) begin
            md_cnt <= CNT_W'(LATENCY - 1);
        end else if (Active && (md_cnt != '0)) begin
            md_cnt <= md_cnt - CNT_W'(1);
        end
    end

    // Busy for the whole wait window, Done on its final cycle
    always_comb begin
        Busy = Active;
        Done = Active && (md_cnt == '0);
    end

endmodule : md_busy_timer

// File: rtl/hazard_stall_ctrl.sv
// Load-use / branch / mul-div hazard controller for the 5-stage pipeline.
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned MD_LATENCY = MD_LATENCY_DEFAULT,
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned STAT_W     = 32
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [4:0]        IFID_Rs,
    input  logic [4:0]        IFID_Rt,
    input  logic              IFID_UsesRt,
    input  logic              IDEX_MemRead,
    input  logic [4:0]        IDEX_DestReg,
    input  logic              Branch_Taken_ID,
    input  logic              MD_Start_ID,
    input  logic              MD_ReadHiLo_ID,
    output logic              PC_Write,
    output logic              IFID_Write,
    output logic              IFID_Flush,
    output logic              IDEX_Flush,
    output logic              MD_Issue,
    output logic              MD_Busy,
    output logic              MD_Done,
    output logic [STAT_W-1:0] Stall_Count
);

    logic [0:0] state;
    logic [0:0] state_nxt;
    logic       load_use;
    logic       md_hazard;
    logic       stall;
    logic       md_load;
    logic       tmr_busy;
    logic       tmr_done;

    // Hazard detection on the ID instruction against EX and the mul/div unit
    always_comb begin
        load_use  = IDEX_MemRead && (IDEX_DestReg != REG_ZERO) &&
                    ((IDEX_DestReg == IFID_Rs) ||
                     (IFID_UsesRt && (IDEX_DestReg == IFID_Rt)));
        md_hazard = (state == MD_WAIT) && (MD_Start_ID || MD_ReadHiLo_ID);
        stall     = load_use || md_hazard;
        md_load   = !Reset && (state == RUN) && MD_Start_ID && !stall;
    end

    md_busy_timer #(
        .LATENCY (MD_LATENCY),
        .CNT_W   (CNT_W)
    ) u_md_busy_timer (
        .Clock  (Clock),
        .Reset  (Reset),
        .Load   (md_load),
        .Active (state == MD_WAIT),
        .Busy   (tmr_busy),
        .Done   (tmr_done)
    );

    // State register
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: enter MD_WAIT on issue, leave after the Done cycle
    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (md_load)  state_nxt = MD_WAIT;
            MD_WAIT: if (tmr_done) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    // Pipeline control outputs; stall wins over a taken branch
    always_comb begin
        PC_Write   = 1'b1;
        IFID_Write = 1'b1;
        IFID_Flush = 1'b0;
        IDEX_Flush = 1'b0;
        MD_Issue   = 1'b0;
        MD_Busy    = 1'b0;
        MD_Done    = 1'b0;
        if (Reset) begin
            PC_Write   = 1'b0;
            IFID_Write = 1'b0;
            IFID_Flush = 1'b1;
            IDEX_Flush = 1'b1;
        end else begin
            if (stall) begin
                PC_Write   = 1'b0;
                IFID_Write = 1'b0;
                IDEX_Flush = 1'b1;
            end else begin
                IFID_Flush = Branch_Taken_ID;
            end
            MD_Issue = md_load;
            MD_Busy  = tmr_busy;
            MD_Done  = tmr_done;
        end
    end

    // Saturating count of stall cycles since reset
    always_ff @(posedge Clock) begin
        if (Reset) begin
            Stall_Count <= '0;
        end else if (stall && (Stall_Count != '1)) begin
            Stall_Count <= Stall_Count + STAT_W'(1);
        end
    end

endmodule : hazard_stall_ctrl

// File: tb/tb_hazard_stall_ctrl.sv
// Directed scoreboard bench for hazard_stall_ctrl (MD_LATENCY=4, STAT_W=4).
module tb_hazard_stall_ctrl;

    localparam int unsigned STAT_W = 4;

    // Control vector order: PC_Write IFID_Write IFID_Flush IDEX_Flush MD_Issue MD_Busy MD_Done
    localparam logic [6:0] C_RST   = 7'b0011000;
    localparam logic [6:0] C_RUN   = 7'b1100000;
    localparam logic [6:0] C_STALL = 7'b0001000;
    localparam logic [6:0] C_BR    = 7'b1110000;
    localparam logic [6:0] C_ISSUE = 7'b1100100;
    localparam logic [6:0] C_BUSY  = 7'b1100010;
    localparam logic [6:0] C_BSTL  = 7'b0001010;
    localparam logic [6:0] C_DSTL  = 7'b0001011;

    typedef struct {
        logic [6:0] ctl;
        int         cnt;
        int         id;
    } exp_t;

    logic              Clock;
    logic              Reset;
    logic [4:0]        IFID_Rs;
    logic [4:0]        IFID_Rt;
    logic              IFID_UsesRt;
    logic              IDEX_MemRead;
    logic [4:0]        IDEX_DestReg;
    logic              Branch_Taken_ID;
    logic              MD_Start_ID;
    logic              MD_ReadHiLo_ID;
    logic              PC_Write;
    logic              IFID_Write;
    logic              IFID_Flush;
    logic              IDEX_Flush;
    logic              MD_Issue;
    logic              MD_Busy;
    logic              MD_Done;
    logic [STAT_W-1:0] Stall_Count;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   step_id = 0;

    hazard_stall_ctrl #(
        .MD_LATENCY (4),
        .CNT_W      (8),
        .STAT_W     (STAT_W)
    ) dut (
        .Clock           (Clock),
        .Reset           (Reset),
        .IFID_Rs         (IFID_Rs),
        .IFID_Rt         (IFID_Rt),
        .IFID_UsesRt     (IFID_UsesRt),
        .IDEX_MemRead    (IDEX_MemRead),
        .IDEX_DestReg    (IDEX_DestReg),
        .Branch_Taken_ID (Branch_Taken_ID),
        .MD_Start_ID     (MD_Start_ID),
        .MD_ReadHiLo_ID  (MD_ReadHiLo_ID),
        .PC_Write        (PC_Write),
        .IFID_Write      (IFID_Write),
        .IFID_Flush      (IFID_Flush),
        .IDEX_Flush      (IDEX_Flush),
        .MD_Issue        (MD_Issue),
        .MD_Busy         (MD_Busy),
        .MD_Done         (MD_Done),
        .Stall_Count     (Stall_Count)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // One cycle: drive inputs, queue the expectation, compare mid-cycle, then clock
    task automatic step(input logic rst, input logic memrd, input logic [4:0] dest,
                        input logic [4:0] rs, input logic [4:0] rt, input logic usesrt,
                        input logic br, input logic mds, input logic mdr,
                        input logic [6:0] ctl, input int cnt);
        exp_t e;
        exp_t got;
        logic [6:0] obs;
        Reset           = rst;
        IDEX_MemRead    = memrd;
        IDEX_DestReg    = dest;
        IFID_Rs         = rs;
        IFID_Rt         = rt;
        IFID_UsesRt     = usesrt;
        Branch_Taken_ID = br;
        MD_Start_ID     = mds;
        MD_ReadHiLo_ID  = mdr;
        e.ctl = ctl;
        e.cnt = cnt;
        e.id  = step_id;
        exp_q.push_back(e);
        @(negedge Clock);
        got = exp_q.pop_front();
        obs = {PC_Write, IFID_Write, IFID_Flush, IDEX_Flush, MD_Issue, MD_Busy, MD_Done};
        n_tests++;
        assert (obs === got.ctl) else begin
            n_fail++;
            $error("FAIL ctl step %0d: observed %b expected %b", got.id, obs, got.ctl);
        end
        if (got.cnt >= 0) begin
            n_tests++;
            assert (Stall_Count === STAT_W'(got.cnt)) else begin
                n_fail++;
                $error("FAIL stall_count step %0d: observed %0d expected %0d",
                       got.id, Stall_Count, got.cnt);
            end
        end
        step_id++;
        @(posedge Clock);
        #1;
    endtask

    initial begin
        //    rst mr dest  rs    rt    ur br ms mh  ctl      cnt
        // Reset held two cycles, then release
        step(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, C_RST,   -1);
        step(1, 0, 5'd0, 5'd0, 5'd0, 0, 1, 1, 0, C_RST,    0);
        step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, C_RUN,    0);

        // Load-use on rs, single bubble, then $zero and unused-rt non-hazards
        step(0, 1, 5'd8, 5'd8, 5'd0, 0, 0, 0, 0, C_STALL,  0);
        step(0, 0, 5'd0, 5'd8, 5'd0, 0, 0, 0, 0, C_RUN,    1);
        step(0, 1, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0, C_RUN,    1);
        step(0, 1, 5'd8, 5'd3, 5'd8, 0, 0, 0, 0, C_RUN,    1);

        // Load-use on rt with a taken branch: stall first, flush next cycle
        step(0, 1, 5'd9, 5'd1, 5'd9, 1, 1, 0, 0, C_STALL,  1);
        step(0, 0, 5'd0, 5'd1, 5'd9, 1, 1, 0, 0, C_BR,     2);
        step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, C_RUN,    2);

        // mult at t, unrelated at t+1, mfhi stalls t+2..t+4, proceeds at t+5
        step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, C_ISSUE,  2);
        step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, C_BUSY,   2);
        step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, C_BSTL,   2);
        step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, C_BSTL,   3);
        step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, C_DSTL,   4);
        step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, C_RUN,    5);
        step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, C_RUN,    5);

        // Back-to-back mult: second stalls through Done, issues at t+5
        step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, C_ISSUE,  5);
        step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, C_BSTL,   5);
        step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, C_BSTL,   6);
        step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, C_BSTL,   7);
        step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, C_DSTL,   8);
        step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, C_ISSUE,  9);

        // Reset at t+2 of that operation aborts it with no Done
        step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, C_BUSY,   9);
        step(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, C_RST,    9);
        step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, C_RUN,    0);
        step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, C_RUN,    0);

        // Held load-use drives the 4-bit counter to saturation and keeps it there
        for (int i = 0; i < 18; i++) begin
            step(0, 1, 5'd8, 5'd8, 5'd0, 0, 0, 0, 0, C_STALL, (i > 15) ? 15 : i);
        end
        step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, C_RUN,   15);

        n_tests++;
        assert (exp_q.size() == 0) else begin
            n_fail++;
            $error("FAIL scoreboard_drain: observed %0d entries expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_hazard_stall_ctrl

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
Pipeline hazard controller for the 5-stage MIPS core. It drives the stall/flush controls of the PC, IF/ID and ID/EX stage registers, including the Flush input of the ID/EX register. It detects load-use hazards and taken branches/jumps resolved in ID. It sequences a multi-cycle mul/div unit, stalling dependent HI/LO readers until the result is ready.

Parameters:
MD_LATENCY, 32, EX-stage mul/div busy cycles after start (2..255).
CNT_W, 8, width of the mul/div countdown counter.
STAT_W, 32, width of the saturating stall-cycle statistics counter.

Ports:
Clock  in  1  system clock.
Reset  in  1  synchronous, active-high reset.
IFID_Rs  in  5  rs field of the instruction in ID.
IFID_Rt  in  5  rt field of the instruction in ID.
IFID_UsesRt  in  1  ID instruction reads rt as a source.
IDEX_MemRead  in  1  MemRead_Out of the ID/EX register.
IDEX_DestReg  in  5  resolved destination register of the EX instruction.
Branch_Taken_ID  in  1  branch/jump in ID resolved taken.
MD_Start_ID  in  1  ID instruction is mult/multu/div/divu.
MD_ReadHiLo_ID  in  1  ID instruction is mfhi/mflo/mthi/mtlo.
PC_Write  out  1  PC load enable.
IFID_Write  out  1  IF/ID register hold when 0.
IFID_Flush  out  1  IF/ID register clear.
IDEX_Flush  out  1  drives the ID/EX register Flush input (bubble insert).
MD_Issue  out  1  one-cycle pulse: mul/div issued into EX this cycle.
MD_Busy  out  1  mul/div unit occupied.
MD_Done  out  1  one-cycle pulse on the last busy cycle.
Stall_Count  out  STAT_W  total stall cycles since reset, saturating.

Behaviour:
- State register: RUN, MD_WAIT. Countdown MD_Cnt[CNT_W-1:0]. All outputs are combinational from the state, MD_Cnt and the current inputs. Only state, MD_Cnt and Stall_Count are registered.
- While Reset=1: PC_Write=0, IFID_Write=0, IFID_Flush=1, IDEX_Flush=1, MD_Issue=0, MD_Busy=0, MD_Done=0.
- Reset values (next edge): state=RUN, MD_Cnt=0, Stall_Count=0.
- load_use = IDEX_MemRead & (IDEX_DestReg!=0) & (IDEX_DestReg==IFID_Rs | (IFID_UsesRt & IDEX_DestReg==IFID_Rt)).
- md_hazard = (state==MD_WAIT) & (MD_Start_ID | MD_ReadHiLo_ID).
- stall = load_use | md_hazard.
- Stall cycle: PC_Write=0, IFID_Write=0, IDEX_Flush=1, IFID_Flush=0, Stall_Count += 1 (holds at all-ones).
- Non-stall cycle: PC_Write=1, IFID_Write=1, IDEX_Flush=0, IFID_Flush=Branch_Taken_ID.
- Priority: stall over branch. A taken branch during a stall is ignored; ID holds, so it re-evaluates next cycle.
- A load-use stall lasts exactly 1 cycle, because the bubble clears IDEX_MemRead.
- RUN transitions:
  - MD_Start_ID & !stall → MD_Issue=1; next state MD_WAIT, MD_Cnt=MD_LATENCY-1.
  - MD_Start_ID with load_use → no issue; retried next cycle.
- MD_WAIT:
  - MD_Busy=1 and MD_Cnt decrements every cycle, whether stalled or not.
  - Unrelated instructions flow without stalling.
  - When MD_Cnt==0: MD_Done=1 and next state=RUN. The stalled reader proceeds on the following cycle.
  - A new MD_Start_ID during MD_WAIT stalls, including on the Done cycle. It issues next cycle from RUN.
- MD_Busy=0 and MD_Done=0 in RUN.
- Reset asserted mid-MD_WAIT aborts the operation: RUN and MD_Cnt=0 at the edge, with no MD_Done pulse.
- Register 0 never creates a hazard.

Decomposition:
- Shared package hazard_pkg: state encoding (RUN=1'b0, MD_WAIT=1'b1), default MD_LATENCY, REG_ZERO constant.
- One natural sub-module, md_busy_timer: countdown with load/busy/done.
- Hazard compare logic stays inline.

Test Plan:
1. Reset held 2 cycles → PC_Write=0, IDEX_Flush=1, IFID_Flush=1; after release Stall_Count=0, MD_Busy=0, PC_Write=1.
2. IDEX_MemRead=1, IDEX_DestReg=8, IFID_Rs=8 → one cycle PC_Write=0, IFID_Write=0, IDEX_Flush=1, Stall_Count=1. Same setup with IDEX_DestReg=0 → no stall.
3. Load-use on rt (IFID_Rt=9, IFID_UsesRt=1) concurrent with Branch_Taken_ID=1 → stall cycle with IFID_Flush=0; next cycle IFID_Flush=1, PC_Write=1.
4. MD_Start_ID at cycle t with MD_LATENCY=4 → MD_Issue at t, MD_Busy t+1..t+4, MD_Done at t+4. An mfhi at t+2 stalls cycles t+2..t+4 and proceeds at t+5; Stall_Count=3.
5. Back-to-back mult, mult with MD_LATENCY=4 → second stalls until the Done cycle, then issues at t+5 with MD_Issue=1.
6. Reset asserted at t+2 of a mul/div → RUN next cycle, no MD_Done, MD_Busy=0. Stall_Count held at all-ones (force STAT_W=4) stays 15 on further stalls.
